// File: rtl/data_memory_lsu_if.sv
// data_memory_lsu_if: CPU <-> data memory request/response bundle.
// master = CPU MEM stage, slave = data_memory_lsu.
interface data_memory_lsu_if #(
    parameter int unsigned ADDR_WIDTH = 12
);
    logic [ADDR_WIDTH-1:0] data_memory_address;
    logic [31:0]           data_memory_data_in;
    logic                  store;
    logic                  load;
    logic [1:0]            access_size;
    logic                  load_unsigned;
    logic                  busy;
    logic                  load_valid;
    logic                  store_ack;
    logic                  mem_fault;
    logic [31:0]           data_memory_data_out;

    modport master (
        output data_memory_address, data_memory_data_in, store, load,
               access_size, load_unsigned,
        input  busy, load_valid, store_ack, mem_fault, data_memory_data_out
    );

    modport slave (
        input  data_memory_address, data_memory_data_in, store, load,
               access_size, load_unsigned,
        output busy, load_valid, store_ack, mem_fault, data_memory_data_out
    );
endinterface

// File: rtl/data_memory_lsu.sv
// data_memory_lsu: RV32I MEM-stage data memory with a load/store sequencer.
// Byte/half/word accesses, sign/zero-extended loads, configurable wait states,
// faulting of misaligned/illegal requests.
// Optional feature macro: DATA_MEMORY_CLEAR_ON_RESET_EN (zero the array after reset).
module data_memory_lsu #(
    parameter int unsigned ADDR_WIDTH  = 12,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic             clk,
    input  logic             rst_n,
    data_memory_lsu_if.slave bus
);
    localparam int unsigned WORD_AW = ADDR_WIDTH - 2;
    localparam int unsigned DEPTH   = 2 ** WORD_AW;
    localparam int unsigned CNT_W   = 4;
    localparam logic [CNT_W-1:0] CNT_INIT = (WAIT_STATES == 0) ? '0 : CNT_W'(WAIT_STATES - 1);

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;

`ifdef DATA_MEMORY_CLEAR_ON_RESET_EN
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP, ST_CLEAR} state_t;
`else
    typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_RESP} state_t;
`endif

    logic [31:0] mem [DEPTH];

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]           wdata_q, wdata_d;
    logic [1:0]            size_q, size_d;
    logic                  uns_q, uns_d;
    logic                  is_store_q, is_store_d;
    logic [31:0]           dout_q, dout_d;
    logic                  busy_q, busy_d;
    logic                  load_valid_q, load_valid_d;
    logic                  store_ack_q, store_ack_d;
    logic                  mem_fault_q, mem_fault_d;
`ifdef DATA_MEMORY_CLEAR_ON_RESET_EN
    logic                  clr_pend_q, clr_pend_d;
    logic [WORD_AW-1:0]    clr_idx_q, clr_idx_d;
`endif

    logic [ADDR_WIDTH-1:0] op_addr;
    logic [31:0]           op_wdata;
    logic [1:0]            op_size;
    logic                  op_uns;
    logic                  op_store;
    logic [31:0]           word_rd;
    logic [7:0]            rd_byte;
    logic [15:0]           rd_half;
    logic [31:0]           load_res;
    logic [3:0]            wr_be;
    logic [31:0]           wr_data;
    logic                  illegal;
    logic                  commit;
    logic                  mem_we;
    logic [WORD_AW-1:0]    mem_widx;
    logic [3:0]            mem_wbe;
    logic [31:0]           mem_wdata;

    // Operand select (live request in IDLE, latched one afterwards) and lane steering
    always_comb begin
        op_addr  = (state_q == ST_IDLE) ? bus.data_memory_address : addr_q;
        op_wdata = (state_q == ST_IDLE) ? bus.data_memory_data_in : wdata_q;
        op_size  = (state_q == ST_IDLE) ? bus.access_size         : size_q;
        op_uns   = (state_q == ST_IDLE) ? bus.load_unsigned       : uns_q;
        op_store = (state_q == ST_IDLE) ? bus.store               : is_store_q;

        word_rd = mem[op_addr[ADDR_WIDTH-1:2]];
        case (op_addr[1:0])
            2'd0:    rd_byte = word_rd[7:0];
            2'd1:    rd_byte = word_rd[15:8];
            2'd2:    rd_byte = word_rd[23:16];
            default: rd_byte = word_rd[31:24];
        endcase
        rd_half = op_addr[1] ? word_rd[31:16] : word_rd[15:0];

        case (op_size)
            SZ_BYTE: begin
                load_res = op_uns ? {24'd0, rd_byte} : {{24{rd_byte[7]}}, rd_byte};
                wr_be    = 4'b0001 << op_addr[1:0];
                wr_data  = {4{op_wdata[7:0]}};
            end
            SZ_HALF: begin
                load_res = op_uns ? {16'd0, rd_half} : {{16{rd_half[15]}}, rd_half};
                wr_be    = op_addr[1] ? 4'b1100 : 4'b0011;
                wr_data  = {2{op_wdata[15:0]}};
            end
            default: begin
                load_res = word_rd;
                wr_be    = 4'b1111;
                wr_data  = op_wdata;
            end
        endcase

        illegal = (bus.load && bus.store)
               || (bus.access_size == 2'b11)
               || (bus.access_size == SZ_HALF && bus.data_memory_address[0])
               || (bus.access_size == SZ_WORD && bus.data_memory_address[1:0] != 2'b00);
    end

    // Sequencer next state, operand latching and registered-output next values
    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        addr_d      = addr_q;
        wdata_d     = wdata_q;
        size_d      = size_q;
        uns_d       = uns_q;
        is_store_d  = is_store_q;
        dout_d      = dout_q;
        mem_fault_d = 1'b0;
        commit      = 1'b0;
`ifdef DATA_MEMORY_CLEAR_ON_RESET_EN
        clr_pend_d  = clr_pend_q;
        clr_idx_d   = clr_idx_q;
`endif
        case (state_q)
            ST_IDLE: begin
`ifdef DATA_MEMORY_CLEAR_ON_RESET_EN
                if (clr_pend_q) begin
                    state_d    = ST_CLEAR;
                    clr_pend_d = 1'b0;
                    clr_idx_d  = '0;
                end else
`endif
                if (bus.load || bus.store) begin
                    if (illegal) begin
                        mem_fault_d = 1'b1;
                    end else begin
                        addr_d     = bus.data_memory_address;
                        wdata_d    = bus.data_memory_data_in;
                        size_d     = bus.access_size;
                        uns_d      = bus.load_unsigned;
                        is_store_d = bus.store;
                        if (WAIT_STATES == 0) begin
                            state_d = ST_RESP;
                            commit  = 1'b1;
                        end else begin
                            state_d = ST_WAIT;
                            cnt_d   = CNT_INIT;
                        end
                    end
                end
            end
            ST_WAIT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RESP;
                    commit  = 1'b1;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            ST_RESP: state_d = ST_IDLE;
`ifdef DATA_MEMORY_CLEAR_ON_RESET_EN
            ST_CLEAR: begin
                clr_idx_d = clr_idx_q + WORD_AW'(1);
                if (clr_idx_q == WORD_AW'(DEPTH - 1)) state_d = ST_IDLE;
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        if (commit && !op_store) dout_d = load_res;

        busy_d       = (state_d != ST_IDLE);
        load_valid_d = (state_d == ST_RESP) && !is_store_d;
        store_ack_d  = (state_d == ST_RESP) && is_store_d;
    end

    // Memory write port: store commit or clear sweep; reset blocks any write
    always_comb begin
        mem_we    = 1'b0;
        mem_widx  = op_addr[ADDR_WIDTH-1:2];
        mem_wbe   = wr_be;
        mem_wdata = wr_data;
        if (commit && op_store) mem_we = rst_n;
`ifdef DATA_MEMORY_CLEAR_ON_RESET_EN
        if (state_q == ST_CLEAR) begin
            mem_we    = rst_n;
            mem_widx  = clr_idx_q;
            mem_wbe   = 4'b1111;
            mem_wdata = '0;
        end
`endif
    end

    // Memory array; contents survive reset
    always_ff @(posedge clk) begin
        if (mem_we) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_wbe[b]) mem[mem_widx][8*b +: 8] <= mem_wdata[8*b +: 8];
            end
        end
    end

    // State and registered outputs, synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            cnt_q        <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            is_store_q   <= 1'b0;
            dout_q       <= '0;
            busy_q       <= 1'b0;
            load_valid_q <= 1'b0;
            store_ack_q  <= 1'b0;
            mem_fault_q  <= 1'b0;
`ifdef DATA_MEMORY_CLEAR_ON_RESET_EN
            clr_pend_q   <= 1'b1;
            clr_idx_q    <= '0;
`endif
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            is_store_q   <= is_store_d;
            dout_q       <= dout_d;
            busy_q       <= busy_d;
            load_valid_q <= load_valid_d;
            store_ack_q  <= store_ack_d;
            mem_fault_q  <= mem_fault_d;
`ifdef DATA_MEMORY_CLEAR_ON_RESET_EN
            clr_pend_q   <= clr_pend_d;
            clr_idx_q    <= clr_idx_d;
`endif
        end
    end

    assign bus.busy                 = busy_q;
    assign bus.load_valid           = load_valid_q;
    assign bus.store_ack            = store_ack_q;
    assign bus.mem_fault            = mem_fault_q;
    assign bus.data_memory_data_out = dout_q;

endmodule

// File: tb/tb_data_memory_lsu.sv
// tb_data_memory_lsu: scoreboard bench; dut0 has WAIT_STATES=0, dut3 has WAIT_STATES=3.
module tb_data_memory_lsu;
    localparam int unsigned AW = 12;
    localparam logic [2:0] K_LD  = 3'b100;
    localparam logic [2:0] K_ST  = 3'b010;
    localparam logic [2:0] K_FLT = 3'b001;

    typedef struct {
        logic [2:0]  kind;
        logic [31:0] data;
    } exp_t;

    logic          clk;
    logic          rst_n;
    bit            sel;
    logic [AW-1:0] addr_v;
    logic [31:0]   din_v;
    logic          load_v;
    logic          store_v;
    logic [1:0]    size_v;
    logic          uns_v;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];

    data_memory_lsu_if #(.ADDR_WIDTH(AW)) if0 ();
    data_memory_lsu_if #(.ADDR_WIDTH(AW)) if3 ();

    assign if0.data_memory_address = addr_v;
    assign if0.data_memory_data_in = din_v;
    assign if0.load                = load_v & ~sel;
    assign if0.store               = store_v & ~sel;
    assign if0.access_size         = size_v;
    assign if0.load_unsigned       = uns_v;
    assign if3.data_memory_address = addr_v;
    assign if3.data_memory_data_in = din_v;
    assign if3.load                = load_v & sel;
    assign if3.store               = store_v & sel;
    assign if3.access_size         = size_v;
    assign if3.load_unsigned       = uns_v;

    data_memory_lsu #(.ADDR_WIDTH(AW), .WAIT_STATES(0)) u_dut0 (
        .clk(clk), .rst_n(rst_n), .bus(if0)
    );
    data_memory_lsu #(.ADDR_WIDTH(AW), .WAIT_STATES(3)) u_dut3 (
        .clk(clk), .rst_n(rst_n), .bus(if3)
    );

    logic        o_busy, o_lv, o_ack, o_flt;
    logic [31:0] o_dout;
    assign o_busy = sel ? if3.busy                 : if0.busy;
    assign o_lv   = sel ? if3.load_valid           : if0.load_valid;
    assign o_ack  = sel ? if3.store_ack            : if0.store_ack;
    assign o_flt  = sel ? if3.mem_fault            : if0.mem_fault;
    assign o_dout = sel ? if3.data_memory_data_out : if0.data_memory_data_out;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Response monitor: every pulse pops one expectation
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && (o_lv || o_ack || o_flt)) begin
            if (sb.size() == 0) begin
                check_eq("unexpected_resp", 32'({o_lv, o_ack, o_flt}), 32'd0);
            end else begin
                e = sb.pop_front();
                check_eq("resp_kind", 32'({o_lv, o_ack, o_flt}), 32'(e.kind));
                if (e.kind == K_LD) check_eq("load_data", o_dout, e.data);
            end
        end
    end

    task automatic issue(input logic ld, input logic st, input logic [AW-1:0] a,
                         input logic [31:0] d, input logic [1:0] sz, input logic uns,
                         input logic [2:0] ek, input logic [31:0] ed, input bit poke);
        int k;
        bit done;
        int lat;
        lat = (ek == K_FLT) ? 1 : (sel ? 4 : 1);
        @(negedge clk);
        addr_v = a; din_v = d; load_v = ld; store_v = st; size_v = sz; uns_v = uns;
        sb.push_back('{kind: ek, data: ed});
        @(posedge clk);
        #1;
        load_v = 1'b0; store_v = 1'b0;
        k = 0;
        done = 1'b0;
        while (!done && k < 40) begin
            @(negedge clk);
            #1;
            k++;
            check_eq("busy_in_flight", 32'(o_busy), (ek == K_FLT) ? 32'd0 : 32'd1);
            if (sb.size() == 0) done = 1'b1;
            if (poke && k == 2) begin
                addr_v = 12'h07C; size_v = 2'b10; load_v = 1'b1;
            end
            if (poke && k == 3) load_v = 1'b0;
        end
        if (!done) begin
            check_eq("resp_timeout", 32'd0, 32'd1);
            sb.delete();
        end else begin
            check_eq("resp_latency", 32'(k), 32'(lat));
        end
        @(negedge clk);
        #1;
        check_eq("busy_back_idle", 32'(o_busy), 32'd0);
    endtask

    task automatic st_op(input logic [AW-1:0] a, input logic [31:0] d, input logic [1:0] sz);
        issue(1'b0, 1'b1, a, d, sz, 1'b0, K_ST, 32'd0, 1'b0);
    endtask

    task automatic ld_op(input logic [AW-1:0] a, input logic [1:0] sz, input logic uns,
                         input logic [31:0] exp, input bit poke);
        issue(1'b1, 1'b0, a, 32'd0, sz, uns, K_LD, exp, poke);
    endtask

    task automatic flt_op(input logic ld, input logic st, input logic [AW-1:0] a, input logic [1:0] sz);
        issue(ld, st, a, 32'hFFFF_FFFF, sz, 1'b0, K_FLT, 32'd0, 1'b0);
    endtask

    // Counts busy cycles after reset release, bounded
    task automatic wait_idle(output int n);
        n = 0;
        while (n < 3000) begin
            @(negedge clk);
            #1;
            if (!o_busy) break;
            n++;
        end
    endtask

    task automatic check_quiet(input string tag);
        check_eq({tag, "_busy"}, 32'(o_busy), 32'd0);
        check_eq({tag, "_lv"},   32'(o_lv),   32'd0);
        check_eq({tag, "_ack"},  32'(o_ack),  32'd0);
        check_eq({tag, "_flt"},  32'(o_flt),  32'd0);
        check_eq({tag, "_dout"}, o_dout,      32'd0);
    endtask

    localparam int CLR_CYC =
`ifdef DATA_MEMORY_CLEAR_ON_RESET_EN
        1024;
`else
        0;
`endif

    initial begin
        int n;
        rst_n = 1'b0; sel = 1'b0;
        addr_v = '0; din_v = '0; load_v = 1'b0; store_v = 1'b0; size_v = 2'b00; uns_v = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        check_quiet("rst0");
        rst_n = 1'b1;
        wait_idle(n);
        check_eq("clear_cycles_init", 32'(n), 32'(CLR_CYC));

        // Word, byte, half stores and extended loads (WAIT_STATES=0)
        st_op(12'h07C, 32'h1234_CDEF, 2'b10);
        ld_op(12'h07C, 2'b10, 1'b0, 32'h1234_CDEF, 1'b0);
        st_op(12'h07D, 32'hFFFF_FF80, 2'b00);
        ld_op(12'h07D, 2'b00, 1'b0, 32'hFFFF_FF80, 1'b0);
        ld_op(12'h07D, 2'b00, 1'b1, 32'h0000_0080, 1'b0);
        ld_op(12'h07C, 2'b10, 1'b0, 32'h1234_80EF, 1'b0);
        st_op(12'h07E, 32'h0000_ABCD, 2'b01);
        ld_op(12'h07E, 2'b01, 1'b0, 32'hFFFF_ABCD, 1'b0);
        ld_op(12'h07E, 2'b01, 1'b1, 32'h0000_ABCD, 1'b0);
        ld_op(12'h07C, 2'b10, 1'b0, 32'hABCD_80EF, 1'b0);
        ld_op(12'h07F, 2'b00, 1'b0, 32'hFFFF_FFAB, 1'b0);
        ld_op(12'h07C, 2'b00, 1'b1, 32'h0000_00EF, 1'b0);
        ld_op(12'h07C, 2'b01, 1'b0, 32'hFFFF_80EF, 1'b0);
        ld_op(12'h07C, 2'b01, 1'b1, 32'h0000_80EF, 1'b0);
        st_op(12'h000, 32'h1122_3344, 2'b10);
        st_op(12'h002, 32'h0000_00A5, 2'b00);
        ld_op(12'h000, 2'b10, 1'b0, 32'h11A5_3344, 1'b0);
        st_op(12'hFFC, 32'hCAFE_BABE, 2'b10);

        // Faults leave memory untouched
        flt_op(1'b1, 1'b0, 12'h07B, 2'b10);
        flt_op(1'b0, 1'b1, 12'h001, 2'b01);
        flt_op(1'b1, 1'b1, 12'hFFF, 2'b00);
        flt_op(1'b1, 1'b0, 12'h07C, 2'b11);
        flt_op(1'b0, 1'b1, 12'h07C, 2'b11);
        flt_op(1'b0, 1'b1, 12'h07E, 2'b10);
        ld_op(12'h07C, 2'b10, 1'b0, 32'hABCD_80EF, 1'b0);
        ld_op(12'h000, 2'b10, 1'b0, 32'h11A5_3344, 1'b0);
        ld_op(12'hFFC, 2'b10, 1'b0, 32'hCAFE_BABE, 1'b0);

        // WAIT_STATES=3 instance, with an ignored request held mid-flight
        @(negedge clk);
        sel = 1'b1;
        st_op(12'h07C, 32'h1234_CDEF, 2'b10);
        ld_op(12'h07C, 2'b10, 1'b0, 32'h1234_CDEF, 1'b1);
        st_op(12'h080, 32'h0BAD_F00D, 2'b10);
        ld_op(12'h080, 2'b10, 1'b0, 32'h0BAD_F00D, 1'b0);

        // Reset one cycle after a store is accepted: store must be dropped
        @(negedge clk);
        addr_v = 12'h080; din_v = 32'h5555_5555; size_v = 2'b10; store_v = 1'b1;
        @(posedge clk);
        #1;
        store_v = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        #1;
        check_quiet("rst_mid");
        rst_n = 1'b1;
        wait_idle(n);
        check_eq("clear_cycles_mid", 32'(n), 32'(CLR_CYC));
`ifdef DATA_MEMORY_CLEAR_ON_RESET_EN
        ld_op(12'h080, 2'b10, 1'b0, 32'h0000_0000, 1'b0);
        ld_op(12'h07C, 2'b10, 1'b0, 32'h0000_0000, 1'b0);
`else
        ld_op(12'h080, 2'b10, 1'b0, 32'h0BAD_F00D, 1'b0);
        ld_op(12'h07C, 2'b10, 1'b0, 32'h1234_CDEF, 1'b0);
`endif

        repeat (3) @(negedge clk);
        #1;
        check_eq("sb_drained", 32'(sb.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
